ksa: RTL and testbench
======================

KSA -- requirements
Module: ksa

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 en  input  1  start request; honoured only in a cycle where rdy=1.
REQ-004 rdy  output  1  1 = idle and able to accept en; 0 = busy.
REQ-005 key  input  24  ARC4 key; key[23:16] is byte 0, key[15:8] is byte 1, key[7:0] is byte 2.
REQ-006 addr  output  8  S-memory address.
REQ-007 rddata  input  8  S-memory read data; valid one cycle after addr is presented with wren=0.
REQ-008 wrdata  output  8  S-memory write data.
REQ-009 wren  output  1  S-memory write enable; the write lands at the rising edge that ends the cycle.

Function
REQ-010 ksa SHALL run the ARC4 key schedule in place on the 256-byte S memory: j=0; for i=0..255 { j=(j+S[i]+key[i mod 3]) mod 256; swap S[i],S[j] }.
REQ-011 All index and j arithmetic SHALL be 8-bit modulo 256; carries are discarded.
REQ-012 Acceptance SHALL occur at the rising edge where en=1 and rdy=1; key SHALL be latched at that edge and i and j cleared to 0.
REQ-013 Changes on key after acceptance SHALL have no effect on the run in progress.
REQ-014 en while rdy=0 SHALL be ignored; it is neither queued nor able to restart the run.
REQ-015 FSM states SHALL be IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J.
REQ-016 IDLE: rdy=1, wren=0; goes to RD_I on acceptance.
REQ-017 RD_I: addr=i, wren=0.
REQ-018 WT_I: capture si=rddata; register j=j+si+keybyte(i mod 3).
REQ-019 RD_J: addr=j (new value), wren=0.
REQ-020 WT_J: capture sj=rddata.
REQ-021 WR_I: addr=i, wrdata=sj, wren=1.
REQ-022 WR_J: addr=j, wrdata=si, wren=1; then go to IDLE if i==255, otherwise increment i and go to RD_I.
REQ-023 Each i SHALL take exactly 6 cycles, so a full run takes 1536 cycles.
REQ-024 rdy SHALL fall in the cycle after the acceptance edge, and SHALL read 1 again in the cycle after the 1536th working edge.
REQ-025 When i==j, both writes target the same address with the original value, leaving that byte unchanged; this case needs no special handling.
REQ-026 wren SHALL be 1 only in WR_I and WR_J; a run SHALL produce exactly 512 write cycles.
REQ-027 A new en accepted in the first IDLE cycle after a run SHALL start a fresh run on the current memory contents with j=0.
REQ-028 ksa SHALL NOT initialise S; the upstream init stage is responsible for loading S[k]=k before en.

Reset
REQ-029 With rst_n=0, asynchronously: state=IDLE, rdy=1, wren=0, addr=0, wrdata=0, i=0, j=0, latched key=0.
REQ-030 Reset mid-run SHALL abort immediately with no further writes; S contents written so far are not restored.
REQ-031 After rst_n rises, the first acceptance of en SHALL behave identically to an acceptance from power-up.

Verification
REQ-032 Byte-order check: S preloaded identity, key=24'h000018, en pulsed.
- Writes for i=0: addr 0 <- 0x00, twice.
- Writes for i=1: addr 1 <- 0x01, twice.
- Writes for i=2: addr 0x02 <- 0x1B, then addr 0x1B <- 0x02.
REQ-033 Key-byte mapping: identity S, key=24'h010000.
- First write pair: addr 0x00 <- 0x01, then addr 0x01 <- 0x00.
REQ-034 Full run: identity S, key=24'h000018.
- Final 256 bytes match a software ARC4 KSA golden model.
- rdy low for exactly 1536 cycles.
- Exactly 512 wren cycles.
REQ-035 Busy and back-to-back start:
- en held high throughout a run: no restart; rdy returns at cycle 1537.
- Then a start in the first IDLE cycle: new run begins with j=0.
REQ-036 Reset mid-run: assert rst_n=0 at cycle 700 of a run.
- Same cycle: rdy=1, wren=0.
- No writes until the next en.
- Next run's first write pair matches REQ-032 for the same S and key.

Source files
------------

// File: rtl/ksa.sv
// ARC4 key-scheduling engine: permutes a 256-byte S memory in place using a 24-bit key.
module ksa (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  addr,
    input  logic [7:0]  rddata,
    output logic [7:0]  wrdata,
    output logic        wren
);

    localparam int unsigned BW = 8;
    localparam int unsigned KW = 24;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_I = 3'd1,
        WT_I = 3'd2,
        RD_J = 3'd3,
        WT_J = 3'd4,
        WR_I = 3'd5,
        WR_J = 3'd6
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [BW-1:0]   i;
    logic [BW-1:0]   i_d;
    logic [BW-1:0]   j;
    logic [BW-1:0]   j_d;
    logic [BW-1:0]   si;
    logic [BW-1:0]   si_d;
    logic [BW-1:0]   sj;
    logic [BW-1:0]   sj_d;
    logic [KW-1:0]   key_q;
    logic [KW-1:0]   key_d;
    logic [1:0]      k;
    logic [1:0]      k_d;
    logic [BW-1:0]   key_byte;
    logic [BW-1:0]   addr_d;
    logic [BW-1:0]   wrdata_d;
    logic            rdy_d;
    logic            wren_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: six cycles per index, back to IDLE after index 255.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (en) state_d = RD_I;
            RD_I:    state_d = WT_I;
            WT_I:    state_d = RD_J;
            RD_J:    state_d = WT_J;
            WT_J:    state_d = WR_I;
            WR_I:    state_d = WR_J;
            WR_J:    state_d = (i == 8'hFF) ? IDLE : RD_I;
            default: state_d = IDLE;
        endcase
    end

    // Key byte for the current i; k tracks i mod 3 so no divider is needed.
    always_comb begin
        case (k)
            2'd0:    key_byte = key_q[23:16];
            2'd1:    key_byte = key_q[15:8];
            default: key_byte = key_q[7:0];
        endcase
    end

    // Datapath next values: key latch, index/j update and the two captured bytes.
    always_comb begin
        i_d   = i;
        j_d   = j;
        si_d  = si;
        sj_d  = sj;
        key_d = key_q;
        k_d   = k;
        case (state)
            IDLE: begin
                if (en) begin
                    key_d = key;
                    i_d   = '0;
                    j_d   = '0;
                    k_d   = '0;
                end
            end
            WT_I: begin
                si_d = rddata;
                j_d  = BW'(j + rddata + key_byte);
            end
            WT_J: begin
                sj_d = rddata;
            end
            WR_J: begin
                i_d = BW'(i + 8'd1);
                k_d = (k == 2'd2) ? 2'd0 : 2'(k + 2'd1);
            end
            default: ;
        endcase
    end

    // Output decode from the upcoming state so the memory port is driven from flops.
    always_comb begin
        rdy_d    = 1'b0;
        wren_d   = 1'b0;
        addr_d   = '0;
        wrdata_d = '0;
        case (state_d)
            IDLE: rdy_d  = 1'b1;
            RD_I: addr_d = i_d;
            WT_I: addr_d = i_d;
            RD_J: addr_d = j_d;
            WT_J: addr_d = j_d;
            WR_I: begin
                addr_d   = i_d;
                wrdata_d = sj_d;
                wren_d   = 1'b1;
            end
            WR_J: begin
                addr_d   = j_d;
                wrdata_d = si_d;
                wren_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i      <= '0;
            j      <= '0;
            si     <= '0;
            sj     <= '0;
            key_q  <= '0;
            k      <= '0;
            rdy    <= 1'b1;
            wren   <= 1'b0;
            addr   <= '0;
            wrdata <= '0;
        end else begin
            i      <= i_d;
            j      <= j_d;
            si     <= si_d;
            sj     <= sj_d;
            key_q  <= key_d;
            k      <= k_d;
            rdy    <= rdy_d;
            wren   <= wren_d;
            addr   <= addr_d;
            wrdata <= wrdata_d;
        end
    end

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: S-memory model, write log and a software KSA reference.
module tb_ksa;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  addr;
    logic [7:0]  rddata;
    logic [7:0]  wrdata;
    logic        wren;

    logic [7:0]  mem [256];
    logic [7:0]  ref_s [256];
    logic        load_id;
    logic [15:0] wq [$];

    int checks;
    int failures;

    typedef struct {
        logic [23:0]      key;
        int               n;
        logic [5:0][15:0] exp;
    } vec_t;

    vec_t vecs [3];

    ksa dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .rdy    (rdy),
        .key    (key),
        .addr   (addr),
        .rddata (rddata),
        .wrdata (wrdata),
        .wren   (wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read S memory with an identity-load hook and a write log.
    always @(posedge clk) begin
        if (load_id) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
        end else if (wren) begin
            mem[addr] <= wrdata;
        end
        rddata <= mem[addr];
        if (wren) wq.push_back({addr, wrdata});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Textbook ARC4 key schedule applied to the reference copy.
    function automatic void ref_ksa(input logic [23:0] k);
        int jj;
        logic [7:0] t;
        logic [7:0] kb;
        jj = 0;
        for (int ii = 0; ii < 256; ii++) begin
            kb = 8'((k >> (8 * (2 - (ii % 3)))) & 24'hFF);
            jj = (jj + int'(ref_s[ii]) + int'(kb)) % 256;
            t = ref_s[ii];
            ref_s[ii] = ref_s[jj];
            ref_s[jj] = t;
        end
    endfunction

    function automatic int mem_diff();
        int n;
        n = 0;
        for (int a = 0; a < 256; a++) begin
            if (mem[a] !== ref_s[a]) n++;
        end
        return n;
    endfunction

    task automatic load_identity();
        @(negedge clk);
        load_id = 1'b1;
        @(negedge clk);
        load_id = 1'b0;
        for (int a = 0; a < 256; a++) ref_s[a] = 8'(a);
    endtask

    // Pulse en for one edge, then scramble key to show it is not re-sampled.
    task automatic start(input logic [23:0] k);
        @(negedge clk);
        key = k;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        key = 24'($urandom);
        check("rdy_fall", 32'(rdy), 32'd0);
    endtask

    task automatic wait_idle(output int busy);
        busy = 0;
        while (rdy == 1'b0 && busy < 3000) begin
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input int v);
        int ws;
        int busy;
        logic [15:0] act;
        load_identity();
        ws = wq.size();
        start(vecs[v].key);
        wait_idle(busy);
        for (int w = 0; w < vecs[v].n; w++) begin
            act = (wq.size() > ws + w) ? wq[ws + w] : 16'hDEAD;
            check($sformatf("vec%0d_wr%0d", v, w), 32'(act), 32'(vecs[v].exp[w]));
        end
        check($sformatf("vec%0d_busy", v), 32'(busy), 32'd1536);
        check($sformatf("vec%0d_writes", v), 32'(wq.size() - ws), 32'd512);
        ref_ksa(vecs[v].key);
        check($sformatf("vec%0d_final_s", v), 32'(mem_diff()), 32'd0);
    endtask

    initial begin
        int busy;
        int busy2;
        int ws;
        logic [23:0] k1;
        logic [23:0] k2;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        key      = '0;
        load_id  = 1'b0;

        vecs[0].key = 24'h000018;
        vecs[0].n   = 6;
        vecs[0].exp = {16'h1B02, 16'h021B, 16'h0101, 16'h0101, 16'h0000, 16'h0000};
        vecs[1].key = 24'h010000;
        vecs[1].n   = 2;
        vecs[1].exp = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0001};
        vecs[2].key = 24'h020100;
        vecs[2].n   = 6;
        vecs[2].exp = {16'h0400, 16'h0201, 16'h0401, 16'h0104, 16'h0200, 16'h0002};

        #12;
        check("reset_rdy", 32'(rdy), 32'd1);
        check("reset_wren", 32'(wren), 32'd0);
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_wrdata", 32'(wrdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 3; v++) run_vec(v);

        // Random keys, chained on whatever the previous run left in S.
        load_identity();
        for (int r = 0; r < 3; r++) begin
            k1 = 24'($urandom);
            repeat (int'($urandom_range(0, 4))) @(negedge clk);
            ws = wq.size();
            start(k1);
            wait_idle(busy);
            check($sformatf("rnd%0d_busy", r), 32'(busy), 32'd1536);
            check($sformatf("rnd%0d_writes", r), 32'(wq.size() - ws), 32'd512);
            ref_ksa(k1);
            check($sformatf("rnd%0d_final_s", r), 32'(mem_diff()), 32'd0);
        end

        // en held high: no restart mid-run, then a new run from the first IDLE cycle.
        load_identity();
        k1 = 24'($urandom);
        k2 = 24'($urandom);
        @(negedge clk);
        key = k1;
        en  = 1'b1;
        @(negedge clk);
        key = k2;
        check("hold_rdy_fall", 32'(rdy), 32'd0);
        wait_idle(busy);
        check("hold_busy", 32'(busy), 32'd1536);
        check("hold_idle_rdy", 32'(rdy), 32'd1);
        @(negedge clk);
        check("b2b_restart", 32'(rdy), 32'd0);
        en  = 1'b0;
        key = 24'($urandom);
        wait_idle(busy2);
        check("b2b_busy", 32'(busy2), 32'd1536);
        ref_ksa(k1);
        ref_ksa(k2);
        check("b2b_final_s", 32'(mem_diff()), 32'd0);

        // Reset at cycle 700 of a run.
        load_identity();
        start(24'h000018);
        repeat (699) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rdy", 32'(rdy), 32'd1);
        check("midrst_wren", 32'(wren), 32'd0);
        ws = wq.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_writes", 32'(wq.size() - ws), 32'd0);
        check("midrst_idle_rdy", 32'(rdy), 32'd1);
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
